// File: rtl/uart_mem_dump_pkg.sv
// Shared constants for the memory-to-UART dump engine and its byte serialiser.
// Holds FSM state encodings, frame geometry and the default bit period.
// Imported by uart_tx_byte and uart_mem_dump.
package uart_mem_dump_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int BYTES_PER_WORD       = 4;
  localparam int DEFAULT_CLKS_PER_BIT = 2604;

  // State encodings. The top-level sequencer uses IDLE/FETCH/WAIT/SEND/FIN;
  // the serialiser uses IDLE/START/DATA/STOP. SEND is the sequencer's view of
  // "a byte is somewhere in START/DATA/STOP inside the serialiser".
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;
  localparam logic [2:0] S_SEND  = 3'd7;

  // Little-endian byte select from a 32-bit word.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serialiser: start bit, 8 data bits LSB first, one stop bit.
// A new byte is accepted in IDLE or in the last cycle of STOP, so back-to-back
// bytes are sent with no idle gap; tx is registered and idles high.
module uart_tx_byte
  import uart_mem_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  logic [2:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          last_baud;

  assign last_baud  = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign byte_ready = (state == S_IDLE) || ((state == S_STOP) && last_baud);

  // Frame sequencing; the baud counter only runs inside START/DATA/STOP.
  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (byte_valid) begin
            shreg <= byte_data;
            state <= S_START;
            tx    <= 1'b0;
          end
        end
        S_START: begin
          if (last_baud) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        S_DATA: begin
          if (last_baud) begin
            baud_cnt <= '0;
            if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        S_STOP: begin
          if (last_baud) begin
            baud_cnt <= '0;
            if (byte_valid) begin
              // Chain straight into the next start bit.
              shreg <= byte_data;
              state <= S_START;
              tx    <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_mem_dump.sv
// Memory-to-UART dump: reads word_cnt words from base_adr upward and sends each
// little-endian over 8N1. Word cost is 1 fetch + RD_LAT wait + 40 bit times.
// start is only honoured in IDLE; the serialiser's ready paces byte hand-off.
module uart_mem_dump
  import uart_mem_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_W       = 14,
  parameter int CNT_W        = 15,
  parameter int RD_LAT       = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_adr,
  input  logic [CNT_W-1:0]  word_cnt,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  input  logic [31:0]       mem_dat_i,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic [31:0]       word_sr;
  logic [1:0]        byte_idx;
  logic [1:0]        lat_cnt;

  logic              last_wait;
  logic              last_byte;
  logic              byte_valid;
  logic              byte_ready;
  logic [7:0]        byte_data;

  assign last_wait = (state == S_WAIT) && (lat_cnt == 2'(RD_LAT - 1));
  assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));

  // Byte 0 is taken straight off the read bus in the capture cycle so its start
  // bit follows WAIT immediately; bytes 1..3 come from word_sr at each STOP end.
  assign byte_valid = last_wait || ((state == S_SEND) && !last_byte);
  assign byte_data  = last_wait ? mem_dat_i[7:0] : word_byte(word_sr, byte_idx + 2'd1);

  assign mem_rd_o  = (state == S_FETCH);
  assign mem_adr_o = addr;
  assign busy      = (state != S_IDLE) && (state != S_FIN);
  assign done      = (state == S_FIN);

  // Word/address sequencing: fetch, wait out read latency, feed four bytes.
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      word_sr   <= '0;
      byte_idx  <= '0;
      lat_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (word_cnt != '0) begin
              addr      <= base_adr;
              remaining <= word_cnt;
              state     <= S_FETCH;
            end else begin
              state <= S_FIN;
            end
          end
        end
        S_FETCH: begin
          lat_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (last_wait) begin
            word_sr  <= mem_dat_i;
            byte_idx <= '0;
            lat_cnt  <= '0;
            state    <= S_SEND;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_SEND: begin
          // byte_ready here means the current byte is in its final stop cycle.
          if (byte_ready) begin
            if (!last_byte) begin
              byte_idx <= byte_idx + 2'd1;
            end else if (remaining > CNT_W'(1)) begin
              remaining <= remaining - CNT_W'(1);
              addr      <= addr + ADDR_W'(1);
              state     <= S_FETCH;
            end else begin
              state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clock      (clock),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .tx         (tx)
  );

endmodule
